// File: rtl/rsa_pkg.sv
// Shared RSA definitions: word width, Fermat exponent constant and key-setup FSM states.
package rsa_pkg;

  localparam int unsigned RSA_WIDTH = 32;
  localparam logic [31:0] E_FERMAT  = 32'd65537;

  typedef logic [RSA_WIDTH-1:0] rsa_word_t;

  typedef enum logic [2:0] {
    StWait,
    StCalc,
    StCheckArgs,
    StGcdStart,
    StGcdRun,
    StTest,
    StNextE,
    StFinished
  } key_state_e;

endpackage

// File: rtl/gcd_unit.sv
// Binary (Stein) gcd, one shift/subtract step per cycle; done pulses for one cycle with gcd held.
module gcd_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] gcd
);

  localparam int unsigned KW = $clog2(WIDTH + 1);

  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, gcd_q, gcd_d;
  logic [KW-1:0]    k_q, k_d;

  always_comb begin
    busy_d = busy_q;
    done_d = 1'b0;
    a_d    = a_q;
    b_d    = b_q;
    k_d    = k_q;
    gcd_d  = gcd_q;
    if (start) begin
      a_d    = a;
      b_d    = b;
      k_d    = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (a_q == '0 || b_q == '0 || a_q == b_q) begin
        // Common power of two removed earlier is restored here.
        gcd_d  = ((a_q == '0) ? b_q : a_q) << k_q;
        done_d = 1'b1;
        busy_d = 1'b0;
      end else if (!a_q[0] && !b_q[0]) begin
        a_d = a_q >> 1;
        b_d = b_q >> 1;
        k_d = k_q + KW'(1);
      end else if (!a_q[0]) begin
        a_d = a_q >> 1;
      end else if (!b_q[0]) begin
        b_d = b_q >> 1;
      end else if (a_q > b_q) begin
        a_d = (a_q - b_q) >> 1;
      end else begin
        b_d = (b_q - a_q) >> 1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      k_q    <= '0;
      gcd_q  <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      a_q    <= a_d;
      b_q    <= b_d;
      k_q    <= k_d;
      gcd_q  <= gcd_d;
    end
  end

  assign done = done_q;
  assign gcd  = gcd_q;

endmodule

// File: rtl/generate_e_phi.sv
// RSA key setup: n = p*q, phi = (p-1)*(q-1), smallest odd e >= E_START coprime to phi.
// Define GENERATE_E_FERMAT_EN to try e = 65537 first when it is below phi.
module generate_e_phi
  import rsa_pkg::*;
#(
  parameter int unsigned WIDTH   = RSA_WIDTH,
  parameter int unsigned E_START = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               compute,
  input  logic [WIDTH/2-1:0] p,
  input  logic [WIDTH/2-1:0] q,
  output logic [WIDTH-1:0]   n,
  output logic [WIDTH-1:0]   phi,
  output logic [WIDTH-1:0]   e,
  output logic               generated_done,
  output logic               key_error
);

  localparam int unsigned HW = WIDTH / 2;
  localparam logic [WIDTH-1:0] EStart = WIDTH'(E_START);

  key_state_e       state_q, state_d;
  logic [HW-1:0]    p_q, p_d, q_q, q_d, pm1, qm1;
  logic [WIDTH-1:0] n_q, n_d, phi_q, phi_d, e_q, e_d, phi_calc;
  logic             done_q, done_d, kerr_q, kerr_d;
  logic [WIDTH:0]   e_sum;
  logic             gcd_start, gcd_done;
  logic [WIDTH-1:0] gcd_val;

`ifdef GENERATE_E_FERMAT_EN
  localparam logic [WIDTH-1:0] EFermat = WIDTH'(E_FERMAT);
  logic fermat_q, fermat_d;
`endif

  assign pm1      = p_q - HW'(1);
  assign qm1      = q_q - HW'(1);
  assign phi_calc = WIDTH'(pm1) * WIDTH'(qm1);
  assign e_sum    = {1'b0, e_q} + (WIDTH + 1)'(2);

  always_comb begin
    state_d   = state_q;
    p_d       = p_q;
    q_d       = q_q;
    n_d       = n_q;
    phi_d     = phi_q;
    e_d       = e_q;
    done_d    = done_q;
    kerr_d    = kerr_q;
    gcd_start = 1'b0;
`ifdef GENERATE_E_FERMAT_EN
    fermat_d  = fermat_q;
`endif
    unique case (state_q)
      StWait: begin
        if (compute) begin
          p_d     = p;
          q_d     = q;
          state_d = StCalc;
        end
      end
      StCalc: begin
        n_d     = WIDTH'(p_q) * WIDTH'(q_q);
        phi_d   = phi_calc;
`ifdef GENERATE_E_FERMAT_EN
        fermat_d = (EFermat < phi_calc);
        e_d      = fermat_d ? EFermat : EStart;
`else
        e_d     = EStart;
`endif
        state_d = StCheckArgs;
      end
      StCheckArgs: begin
        if (p_q < HW'(2) || q_q < HW'(2) || phi_q <= EStart) begin
          kerr_d  = 1'b1;
          done_d  = 1'b1;
          state_d = StFinished;
        end else begin
          state_d = StGcdStart;
        end
      end
      StGcdStart: begin
        gcd_start = 1'b1;
        state_d   = StGcdRun;
      end
      StGcdRun: begin
        if (gcd_done) state_d = StTest;
      end
      StTest: begin
        if (gcd_val == WIDTH'(1)) begin
          done_d  = 1'b1;
          state_d = StFinished;
        end else begin
          state_d = StNextE;
        end
      end
      StNextE: begin
`ifdef GENERATE_E_FERMAT_EN
        if (fermat_q) begin
          // 65537 rejected: fall back to the normal linear search.
          fermat_d = 1'b0;
          e_d      = EStart;
          state_d  = StGcdStart;
        end else
`endif
        begin
          e_d = e_sum[WIDTH-1:0];
          if (e_sum[WIDTH] || e_sum[WIDTH-1:0] >= phi_q) begin
            kerr_d  = 1'b1;
            done_d  = 1'b1;
            state_d = StFinished;
          end else begin
            state_d = StGcdStart;
          end
        end
      end
      StFinished: begin
        if (!compute) begin
          done_d  = 1'b0;
          kerr_d  = 1'b0;
          state_d = StWait;
        end
      end
      default: state_d = StWait;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StWait;
      p_q     <= '0;
      q_q     <= '0;
      n_q     <= '0;
      phi_q   <= '0;
      e_q     <= '0;
      done_q  <= 1'b0;
      kerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      q_q     <= q_d;
      n_q     <= n_d;
      phi_q   <= phi_d;
      e_q     <= e_d;
      done_q  <= done_d;
      kerr_q  <= kerr_d;
    end
  end

`ifdef GENERATE_E_FERMAT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) fermat_q <= 1'b0;
    else          fermat_q <= fermat_d;
  end
`endif

  gcd_unit #(
    .WIDTH(WIDTH)
  ) u_gcd (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (gcd_start),
    .a      (e_q),
    .b      (phi_q),
    .done   (gcd_done),
    .gcd    (gcd_val)
  );

  assign n              = n_q;
  assign phi            = phi_q;
  assign e              = e_q;
  assign generated_done = done_q;
  assign key_error      = kerr_q;

endmodule

// File: tb/tb_generate_e_phi.sv
// Directed bench for generate_e_phi with hand-computed key values.
module tb_generate_e_phi;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        compute = 1'b0;
  logic [15:0] p = '0;
  logic [15:0] q = '0;
  logic [31:0] n, phi, e;
  logic        generated_done, key_error;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef GENERATE_E_FERMAT_EN
  localparam logic [31:0] ExpE3 = 32'd65537;
`else
  localparam logic [31:0] ExpE3 = 32'd3;
`endif

  always #5 clk = ~clk;

  generate_e_phi #(
    .WIDTH  (32),
    .E_START(3)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .compute       (compute),
    .p             (p),
    .q             (q),
    .n             (n),
    .phi           (phi),
    .e             (e),
    .generated_done(generated_done),
    .key_error     (key_error)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic request(input logic [15:0] pv, input logic [15:0] qv);
    @(negedge clk);
    p       = pv;
    q       = qv;
    compute = 1'b1;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (generated_done) break;
    end
    check_eq({tag, "_done"}, {31'd0, generated_done}, 32'd1);
  endtask

  task automatic release_req(input string tag);
    @(negedge clk);
    compute = 1'b0;
    @(negedge clk);
    check_eq({tag, "_done_clr"}, {31'd0, generated_done}, 32'd0);
    check_eq({tag, "_kerr_clr"}, {31'd0, key_error}, 32'd0);
  endtask

  task automatic check_key(input string tag, input logic [31:0] en, input logic [31:0] ephi,
                           input logic [31:0] ee, input logic ekerr);
    check_eq({tag, "_n"}, n, en);
    check_eq({tag, "_phi"}, phi, ephi);
    if (!ekerr) check_eq({tag, "_e"}, e, ee);
    check_eq({tag, "_kerr"}, {31'd0, key_error}, {31'd0, ekerr});
  endtask

  initial begin
    #1;
    check_eq("rst_n", n, 32'd0);
    check_eq("rst_phi", phi, 32'd0);
    check_eq("rst_e", e, 32'd0);
    check_eq("rst_done", {31'd0, generated_done}, 32'd0);
    check_eq("rst_kerr", {31'd0, key_error}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // p/q change after sampling must be ignored.
    request(16'd61, 16'd53);
    @(negedge clk);
    p = 16'hffff;
    q = 16'hffff;
    wait_done("k61");
    check_key("k61", 32'd3233, 32'd3120, 32'd7, 1'b0);
    release_req("k61");

    request(16'd3, 16'd11);
    wait_done("k3");
    check_key("k3", 32'd33, 32'd20, 32'd3, 1'b0);
    repeat (3) @(negedge clk);
    check_eq("k3_done_hold", {31'd0, generated_done}, 32'd1);
    check_eq("k3_e_hold", e, 32'd3);
    release_req("k3");
    check_eq("k3_n_kept", n, 32'd33);

    request(16'd257, 16'd263);
    wait_done("k257");
    check_key("k257", 32'd67591, 32'd67072, ExpE3, 1'b0);
    release_req("k257");

    request(16'd2, 16'd3);
    wait_done("k2");
    check_key("k2", 32'd6, 32'd2, 32'd0, 1'b1);
    release_req("k2");

    request(16'd1, 16'd13);
    wait_done("k1");
    check_key("k1", 32'd13, 32'd0, 32'd0, 1'b1);
    release_req("k1");

    // Abort with reset while the gcd is running, then re-request.
    request(16'd61, 16'd53);
    repeat (5) @(negedge clk);
    check_eq("abort_pre_n", n, 32'd3233);
    check_eq("abort_pre_done", {31'd0, generated_done}, 32'd0);
    reset_n = 1'b0;
    #1;
    check_eq("abort_n", n, 32'd0);
    check_eq("abort_phi", phi, 32'd0);
    check_eq("abort_e", e, 32'd0);
    check_eq("abort_done", {31'd0, generated_done}, 32'd0);
    check_eq("abort_kerr", {31'd0, key_error}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    wait_done("rerun");
    check_key("rerun", 32'd3233, 32'd3120, 32'd7, 1'b0);
    release_req("rerun");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
